// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-only data memory (no byte enables).
// Optional range check on the upper address bits: define LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
    parameter int MEM_IDX_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is taken at the rising edge where req_valid && req_ready;
    // the response is a one-cycle resp_valid pulse, with resp_err qualifying it.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [31:0] r_merged;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_accept;
    logic        w_legal;
    logic        w_misal;
    logic        w_oob;
    logic        w_err;
    logic        w_is_sw;
    logic [4:0]  w_shamt;
    logic [31:0] w_lane;
    logic [31:0] w_load_ext;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_we;
            default:                w_legal = 1'b0;
        endcase
        w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_BOUNDS_CHECK_EN
        w_oob = |req_addr[31:MEM_IDX_BITS+2];
`else
        w_oob = 1'b0;
`endif
        w_err = !w_legal || w_misal || w_oob;
    end

    assign w_is_sw = r_we && (r_funct3 == 3'b010);

    // Lane selection and sub-word merge both key off the latched byte offset.
    always_comb begin
        w_shamt = {r_addr[1:0], 3'b000};
        w_lane  = mem_rdata >> w_shamt;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_ext = {24'h000000, w_lane[7:0]};
            3'b101:  w_load_ext = {16'h0000, w_lane[15:0]};
            default: w_load_ext = w_lane;
        endcase
        if (r_funct3[0]) begin
            w_mask = 32'h0000FFFF << w_shamt;
            w_ins  = {16'h0000, r_wdata[15:0]} << w_shamt;
        end else begin
            w_mask = 32'h000000FF << w_shamt;
            w_ins  = {24'h000000, r_wdata[7:0]} << w_shamt;
        end
        w_merged = (mem_rdata & ~w_mask) | (w_ins & w_mask);
    end

    // mem_we comes only from state, so an async reset removes it at once.
    always_comb begin
        w_next    = r_state;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_err) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                w_next = (r_we && !w_is_sw) ? S_WRITE : S_IDLE;
                if (w_is_sw) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_wdata;
                end
            end
            S_WRITE: begin
                w_next    = S_IDLE;
                mem_we    = 1'b1;
                mem_wdata = r_merged;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_funct3     <= 3'b000;
            r_we         <= 1'b0;
            r_merged     <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_we     <= req_we;
                if (w_err) begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_resp_rdata <= 32'h0;
                end
            end
            case (r_state)
                S_ACCESS: begin
                    if (!r_we) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_ext;
                    end else if (w_is_sw) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= 32'h0;
                    end else begin
                        r_merged <= w_merged;
                    end
                end
                S_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= 32'h0;
                end
                default: ;
            endcase
        end
    end

    // Upper address bits pass through untouched; the memory aliases on them.
    assign mem_addr   = {2'b00, r_addr[31:MEM_IDX_BITS+2], r_addr[MEM_IDX_BITS+1:2]};
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign dbg_state  = r_state;

endmodule
